pe_id_scan_ctrl: RTL and testbench
==================================

# pe_id_scan_ctrl

Configuration sequencer for the PE array. On `start` it computes the mapping for one layer:
- per-PE ifmap/filter/ipsum/opsum X/Y tags,
- the vertical local-network (LN) links,
- the PE enable mask.

It then drives the array's serial scan inputs (`SET_XID`, `SET_YID`, `SET_LN`) in the exact order the scan chains expect. It sits between the top-level layer controller and the PE array, and runs once per layer before any GLB traffic.

## Interface
Parameters:
- NUMS_PE_ROW, default `NUMS_PE_ROW (12), PE rows
- NUMS_PE_COL, default `NUMS_PE_COL (14), PE columns
- XID_BITS, default `XID_BITS, X tag width; all-ones value reserved as "never match"
- YID_BITS, default `YID_BITS, Y tag width; all-ones value reserved

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  start pulse; sampled only in IDLE
- cfg_r  in  4  PE-set height (filter rows), 1..NUMS_PE_ROW
- cfg_e  in  4  used columns, 1..NUMS_PE_COL
- cfg_t  in  4  sets stacked vertically, with cfg_r*cfg_t ≤ NUMS_PE_ROW
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle pulse
- err  out  1  one-cycle pulse on a rejected start
- SET_XID  out  1  XID shift enable
- ifmap_XID_scan_in, filter_XID_scan_in, ipsum_XID_scan_in, opsum_XID_scan_in  out  XID_BITS each
- SET_YID  out  1  YID shift enable
- ifmap_YID_scan_in, filter_YID_scan_in, ipsum_YID_scan_in, opsum_YID_scan_in  out  YID_BITS each
- SET_LN  out  1  LN load strobe
- LN_config_in  out  NUMS_PE_ROW-1  LN link vector
- PE_en  out  NUMS_PE_ROW*NUMS_PE_COL  registered enable mask

## Operation
FSM states:
- IDLE → SCAN_X on a valid start.
- IDLE → IDLE with an `err` pulse on an invalid start: any field 0, cfg_e > NUMS_PE_COL, or cfg_r*cfg_t > NUMS_PE_ROW.
- SCAN_X → SCAN_Y after NUMS_PE_ROW*NUMS_PE_COL shifts.
- SCAN_Y → LOAD_LN after NUMS_PE_ROW shifts.
- LOAD_LN → DONE.
- DONE → IDLE.

Config latching and counters:
- cfg_* is latched at the accepted start.
- start while busy is ignored, with no err.
- Scan order is PE index k = y*NUMS_PE_COL + x, k = 0 first, so entry 0 lands in array slot 0 after the final shift.
- YID scan order is y = 0 first.
- Counters are y, x, y_in_set (y mod r) and set_idx (y div r), advanced incrementally; no dividers.

A PE (y,x) is active iff y < r*t and x < e. Tag values for an active PE:
- ifmap: X = x + y_in_set, Y = set_idx
- filter: X = 0, Y = y_in_set
- ipsum: X = x, Y = set_idx
- opsum: X = x, Y = set_idx

YID values for row y use the same rules evaluated with x = 0. Rows y ≥ r*t get all-ones YIDs.

LN and enable outputs:
- LN_config_in[i] = 1 iff (i+1) mod r ≠ 0 and i+1 < r*t, i.e. row i feeds row i+1 within the same set.
- PE_en is updated in LOAD_LN and holds until the next done or reset.

## Timing
- Start sampled at cycle 0.
- SET_XID is high in cycles 1..N, where N = NUMS_PE_ROW*NUMS_PE_COL.
- SET_YID is high in cycles N+1..N+NUMS_PE_ROW.
- SET_LN is high in cycle N+NUMS_PE_ROW+1; PE_en updates at the same clock edge.
- done is asserted in cycle N+NUMS_PE_ROW+2. For 12×14 this is cycle 182.
- All outputs are registered; scan data is valid in the same cycle as its strobe.
- Reset value of every output is 0, including PE_en and all scan data.
- Reset mid-scan: FSM returns to IDLE and all strobes drop in the next cycle. The array is left partially scanned, and the layer controller must restart.
- The cycle after done returns to IDLE; start is accepted there.

## Configuration
- PE_SCAN_MASK_UNUSED_EN defined:
  - inactive PEs get all-ones XIDs and all-ones YIDs in all four tag classes;
  - their PE_en bit is 0.
- PE_SCAN_MASK_UNUSED_EN undefined:
  - every PE gets the computed tags regardless of activity;
  - PE_en is all ones;
  - YIDs for rows ≥ r*t are computed normally.
- LN rules are identical in both builds.

## Structure
- Shared package: FSM state encoding; tag all-ones constant; the config-validity rule as a function, also used by the layer controller.
- One sub-module, `pe_scan_cnt`: the y/x/y_in_set/set_idx counter chain with wrap logic. The FSM and tag mapping stay in the top module.

## Test plan
- r=3, e=14, t=4, mask build:
  - LN_config_in = 11'b11011011011;
  - PE(4,5) ifmap X=6, filter Y=1, ipsum Y=1;
  - PE_en all ones;
  - done at cycle 182.
- r=3, e=10, t=2, mask build:
  - PE_en bits for x ≥ 10 or y ≥ 6 are 0, and those PEs' XIDs are all-ones;
  - rows 6..11 YID all-ones;
  - LN_config_in = 11'b00000011011.
- Invalid starts:
  - start with r=5, t=3 → err pulse, busy stays 0, no strobes;
  - start with e=0 → err.
- Second start at cycle 50 of a scan → ignored; SET_XID count stays exactly 168.
- rst at cycle 100 → all outputs 0 the next cycle; a fresh start completes normally.
- Unmasked build, r=1, e=1, t=1 → PE_en all ones, LN_config_in = 0, PE(11,13) ifmap X=13.

Source files
------------

// File: rtl/pe_id_scan_ctrl_pkg.sv
// Shared definitions for the PE-array configuration sequencer:
// FSM state encoding, the all-ones "never match" tag constant and the
// layer-config validity rule (also used by the layer controller).
`ifndef NUMS_PE_ROW
`define NUMS_PE_ROW 12
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 14
`endif
`ifndef XID_BITS
`define XID_BITS 5
`endif
`ifndef YID_BITS
`define YID_BITS 4
`endif

package pe_id_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN_X,
    ST_SCAN_Y,
    ST_LOAD_LN,
    ST_DONE
  } scan_state_e;

  localparam int CFG_W = 4;

  // Sliced down to XID_BITS / YID_BITS by users; all-ones never matches.
  localparam logic [31:0] TAG_ALL_ONES = 32'hFFFF_FFFF;

  // A layer config is usable when no field is zero, the used columns fit
  // and the vertically stacked sets fit in the array rows.
  function automatic logic cfg_valid(input logic [CFG_W-1:0] r,
                                     input logic [CFG_W-1:0] e,
                                     input logic [CFG_W-1:0] t,
                                     input int rows,
                                     input int cols);
    logic [2*CFG_W-1:0] rt;
    rt = {{CFG_W{1'b0}}, r} * {{CFG_W{1'b0}}, t};
    return (r != '0) && (e != '0) && (t != '0) &&
           (int'(e) <= cols) && (int'(rt) <= rows);
  endfunction

endpackage

// File: rtl/pe_id_scan_ctrl_scan_cnt.sv
// pe_scan_cnt: PE index counter chain for the scan sequencer.
// Holds the (y, x) position of the next entry to emit plus y mod r
// (y_in_set) and y div r (set_idx), all advanced incrementally.
// In row mode x stays at 0 and only the row counters step.
module pe_scan_cnt
  import pe_id_scan_ctrl_pkg::*;
#(
  parameter int NUMS_PE_ROW = `NUMS_PE_ROW,
  parameter int NUMS_PE_COL = `NUMS_PE_COL,
  localparam int Y_W = $clog2(NUMS_PE_ROW),
  localparam int X_W = $clog2(NUMS_PE_COL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             row_mode_i,
  input  logic [CFG_W-1:0] cfg_r_i,
  output logic [Y_W-1:0]   y_o,
  output logic [X_W-1:0]   x_o,
  output logic [CFG_W-1:0] yis_o,
  output logic [CFG_W-1:0] set_o
);

  logic [Y_W-1:0]   y_q, y_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [CFG_W-1:0] yis_q, yis_d;
  logic [CFG_W-1:0] set_q, set_d;

  // Next position: x wraps into y; y_in_set wraps at r into set_idx;
  // the last row wraps everything back to the origin.
  always_comb begin
    y_d   = y_q;
    x_d   = x_q;
    yis_d = yis_q;
    set_d = set_q;
    if (clr_i) begin
      y_d   = '0;
      x_d   = '0;
      yis_d = '0;
      set_d = '0;
    end else if (inc_i) begin
      if (!row_mode_i && (x_q != X_W'(NUMS_PE_COL - 1))) begin
        x_d = x_q + 1'b1;
      end else begin
        x_d = '0;
        if (y_q == Y_W'(NUMS_PE_ROW - 1)) begin
          y_d   = '0;
          yis_d = '0;
          set_d = '0;
        end else begin
          y_d = y_q + 1'b1;
          if (yis_q == cfg_r_i - 1'b1) begin
            yis_d = '0;
            set_d = set_q + 1'b1;
          end else begin
            yis_d = yis_q + 1'b1;
          end
        end
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      x_q   <= '0;
      yis_q <= '0;
      set_q <= '0;
    end else begin
      y_q   <= y_d;
      x_q   <= x_d;
      yis_q <= yis_d;
      set_q <= set_d;
    end
  end

  assign y_o   = y_q;
  assign x_o   = x_q;
  assign yis_o = yis_q;
  assign set_o = set_q;

endmodule

// File: rtl/pe_id_scan_ctrl.sv
// pe_id_scan_ctrl: per-layer PE array configuration sequencer.
// On an accepted start it shifts X tags for every PE (index 0 first),
// then Y tags for every row (row 0 first), then loads the LN links and
// the PE enable mask, and pulses done.
// Build option PE_SCAN_MASK_UNUSED_EN: inactive PEs get all-ones tags and
// a cleared enable bit; without it every PE gets computed tags and is enabled.
module pe_id_scan_ctrl
  import pe_id_scan_ctrl_pkg::*;
#(
  parameter int NUMS_PE_ROW = `NUMS_PE_ROW,
  parameter int NUMS_PE_COL = `NUMS_PE_COL,
  parameter int XID_BITS    = `XID_BITS,
  parameter int YID_BITS    = `YID_BITS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [3:0]                         cfg_r,
  input  logic [3:0]                         cfg_e,
  input  logic [3:0]                         cfg_t,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic                               SET_XID,
  output logic [XID_BITS-1:0]                ifmap_XID_scan_in,
  output logic [XID_BITS-1:0]                filter_XID_scan_in,
  output logic [XID_BITS-1:0]                ipsum_XID_scan_in,
  output logic [XID_BITS-1:0]                opsum_XID_scan_in,
  output logic                               SET_YID,
  output logic [YID_BITS-1:0]                ifmap_YID_scan_in,
  output logic [YID_BITS-1:0]                filter_YID_scan_in,
  output logic [YID_BITS-1:0]                ipsum_YID_scan_in,
  output logic [YID_BITS-1:0]                opsum_YID_scan_in,
  output logic                               SET_LN,
  output logic [NUMS_PE_ROW-2:0]             LN_config_in,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_en
);

  localparam int Y_W  = $clog2(NUMS_PE_ROW);
  localparam int X_W  = $clog2(NUMS_PE_COL);
  localparam int PE_N = NUMS_PE_ROW * NUMS_PE_COL;

  scan_state_e state_q;
  logic [3:0]  r_q, t_q, r_eff, t_eff;
  logic [7:0]  rt;
  logic        go, cnt_zero, x_last, y_last, emit_x, emit_y;
  logic        cnt_clr, cnt_inc, row_mode;
  logic [Y_W-1:0] y_cnt;
  logic [X_W-1:0] x_cnt;
  logic [3:0]  yis_cnt, set_cnt;
  logic [XID_BITS-1:0] ifm_x, flt_x, ips_x, ops_x;
  logic [YID_BITS-1:0] ifm_y, flt_y, ips_y, ops_y;
  logic [NUMS_PE_ROW-2:0] ln_d;
  logic [PE_N-1:0] en_d;
  int ln_run;

`ifdef PE_SCAN_MASK_UNUSED_EN
  localparam logic [XID_BITS-1:0] XID_ONES = XID_BITS'(TAG_ALL_ONES);
  localparam logic [YID_BITS-1:0] YID_ONES = YID_BITS'(TAG_ALL_ONES);
  logic [3:0] e_q, e_eff;
  logic       act;
`endif

  // In IDLE the config is still on the inputs; afterwards use the latched copy.
  assign r_eff = (state_q == ST_IDLE) ? cfg_r : r_q;
  assign t_eff = (state_q == ST_IDLE) ? cfg_t : t_q;
  assign rt    = {4'd0, r_eff} * {4'd0, t_eff};

  // Sequencing decisions; the counter always points at the next entry to emit,
  // so a return to the origin means the current scan phase is exhausted.
  always_comb begin
    go       = (state_q == ST_IDLE) && start &&
               cfg_valid(cfg_r, cfg_e, cfg_t, NUMS_PE_ROW, NUMS_PE_COL);
    cnt_zero = (y_cnt == '0) && (x_cnt == '0);
    x_last   = (state_q == ST_SCAN_X) && cnt_zero;
    y_last   = (state_q == ST_SCAN_Y) && (y_cnt == '0);
    emit_x   = go || ((state_q == ST_SCAN_X) && !cnt_zero);
    emit_y   = x_last || ((state_q == ST_SCAN_Y) && !y_last);
    cnt_inc  = emit_x || emit_y;
    cnt_clr  = !cnt_inc && (state_q != ST_SCAN_X) && (state_q != ST_SCAN_Y);
    row_mode = emit_y;
  end

  pe_scan_cnt #(
    .NUMS_PE_ROW (NUMS_PE_ROW),
    .NUMS_PE_COL (NUMS_PE_COL)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .row_mode_i (row_mode),
    .cfg_r_i    (r_eff),
    .y_o        (y_cnt),
    .x_o        (x_cnt),
    .yis_o      (yis_cnt),
    .set_o      (set_cnt)
  );

`ifdef PE_SCAN_MASK_UNUSED_EN
  assign e_eff = (state_q == ST_IDLE) ? cfg_e : e_q;
  assign act   = (int'(y_cnt) < int'(rt)) && (int'(x_cnt) < int'(e_eff));
`endif

  // Tag mapping for the PE (or row, with x = 0) under the counter.
  always_comb begin
    ifm_x = XID_BITS'(x_cnt) + XID_BITS'(yis_cnt);
    flt_x = '0;
    ips_x = XID_BITS'(x_cnt);
    ops_x = XID_BITS'(x_cnt);
    ifm_y = YID_BITS'(set_cnt);
    flt_y = YID_BITS'(yis_cnt);
    ips_y = YID_BITS'(set_cnt);
    ops_y = YID_BITS'(set_cnt);
`ifdef PE_SCAN_MASK_UNUSED_EN
    if (!act) begin
      ifm_x = XID_ONES;
      flt_x = XID_ONES;
      ips_x = XID_ONES;
      ops_x = XID_ONES;
      ifm_y = YID_ONES;
      flt_y = YID_ONES;
      ips_y = YID_ONES;
      ops_y = YID_ONES;
    end
`endif
  end

  // LN link i joins row i to row i+1 unless i+1 starts a new set or leaves the used rows.
  always_comb begin
    ln_d   = '0;
    ln_run = 0;
    for (int i = 0; i < NUMS_PE_ROW - 1; i++) begin
      ln_run = ln_run + 1;
      if (ln_run == int'(r_eff)) ln_run = 0;
      ln_d[i] = (ln_run != 0) && ((i + 1) < int'(rt));
    end
  end

  // PE enable mask for the current layer.
  always_comb begin
`ifdef PE_SCAN_MASK_UNUSED_EN
    en_d = '0;
    for (int yy = 0; yy < NUMS_PE_ROW; yy++) begin
      for (int xx = 0; xx < NUMS_PE_COL; xx++) begin
        en_d[yy*NUMS_PE_COL + xx] = (yy < int'(rt)) && (xx < int'(e_eff));
      end
    end
`else
    en_d = '1;
`endif
  end

  // Config latch at the accepted start; data only, never reset.
  always_ff @(posedge clk) begin
    if (go) begin
      r_q <= cfg_r;
      t_q <= cfg_t;
`ifdef PE_SCAN_MASK_UNUSED_EN
      e_q <= cfg_e;
`endif
    end
  end

  // Sequencer FSM with registered strobes, scan data and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      SET_XID            <= 1'b0;
      SET_YID            <= 1'b0;
      SET_LN             <= 1'b0;
      ifmap_XID_scan_in  <= '0;
      filter_XID_scan_in <= '0;
      ipsum_XID_scan_in  <= '0;
      opsum_XID_scan_in  <= '0;
      ifmap_YID_scan_in  <= '0;
      filter_YID_scan_in <= '0;
      ipsum_YID_scan_in  <= '0;
      opsum_YID_scan_in  <= '0;
      LN_config_in       <= '0;
      PE_en              <= '0;
    end else begin
      done               <= 1'b0;
      err                <= 1'b0;
      SET_LN             <= 1'b0;
      SET_XID            <= emit_x;
      SET_YID            <= emit_y;
      ifmap_XID_scan_in  <= emit_x ? ifm_x : '0;
      filter_XID_scan_in <= emit_x ? flt_x : '0;
      ipsum_XID_scan_in  <= emit_x ? ips_x : '0;
      opsum_XID_scan_in  <= emit_x ? ops_x : '0;
      ifmap_YID_scan_in  <= emit_y ? ifm_y : '0;
      filter_YID_scan_in <= emit_y ? flt_y : '0;
      ipsum_YID_scan_in  <= emit_y ? ips_y : '0;
      opsum_YID_scan_in  <= emit_y ? ops_y : '0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q <= ST_SCAN_X;
            busy    <= 1'b1;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        ST_SCAN_X: if (x_last) state_q <= ST_SCAN_Y;
        ST_SCAN_Y: begin
          if (y_last) begin
            state_q      <= ST_LOAD_LN;
            SET_LN       <= 1'b1;
            LN_config_in <= ln_d;
            PE_en        <= en_d;
          end
        end
        ST_LOAD_LN: begin
          state_q <= ST_DONE;
          done    <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_id_scan_ctrl.sv
// Directed testbench for pe_id_scan_ctrl (12x14 array, 5-bit XID, 4-bit YID).
// Expectations follow the PE_SCAN_MASK_UNUSED_EN setting of the build.
module tb_pe_id_scan_ctrl;

  localparam int ROW = 12;
  localparam int COL = 14;
  localparam int N   = ROW * COL;
`ifdef PE_SCAN_MASK_UNUSED_EN
  localparam bit MASKED = 1'b1;
`else
  localparam bit MASKED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  logic [3:0] cfg_r, cfg_e, cfg_t;
  logic busy, done, err, SET_XID, SET_YID, SET_LN;
  logic [4:0] ifmap_XID_scan_in, filter_XID_scan_in, ipsum_XID_scan_in, opsum_XID_scan_in;
  logic [3:0] ifmap_YID_scan_in, filter_YID_scan_in, ipsum_YID_scan_in, opsum_YID_scan_in;
  logic [ROW-2:0] LN_config_in;
  logic [N-1:0]   PE_en;

  pe_id_scan_ctrl #(
    .NUMS_PE_ROW (ROW),
    .NUMS_PE_COL (COL),
    .XID_BITS    (5),
    .YID_BITS    (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .cfg_r              (cfg_r),
    .cfg_e              (cfg_e),
    .cfg_t              (cfg_t),
    .busy               (busy),
    .done               (done),
    .err                (err),
    .SET_XID            (SET_XID),
    .ifmap_XID_scan_in  (ifmap_XID_scan_in),
    .filter_XID_scan_in (filter_XID_scan_in),
    .ipsum_XID_scan_in  (ipsum_XID_scan_in),
    .opsum_XID_scan_in  (opsum_XID_scan_in),
    .SET_YID            (SET_YID),
    .ifmap_YID_scan_in  (ifmap_YID_scan_in),
    .filter_YID_scan_in (filter_YID_scan_in),
    .ipsum_YID_scan_in  (ipsum_YID_scan_in),
    .opsum_YID_scan_in  (opsum_YID_scan_in),
    .SET_LN             (SET_LN),
    .LN_config_in       (LN_config_in),
    .PE_en              (PE_en)
  );

  int checks = 0;
  int errors = 0;

  logic [4:0] cap_ifx[N], cap_flx[N], cap_ipx[N], cap_opx[N];
  logic [3:0] cap_ify[ROW], cap_fly[ROW], cap_ipy[ROW], cap_opy[ROW];
  int xcnt, ycnt, ln_cyc, done_cyc, busy_cnt, err_cnt;
  logic [N-1:0] exp_en;

  // Issue one start (sampled at cycle 0) and record everything up to done.
  task automatic run_scan(input logic [3:0] r, input logic [3:0] e,
                          input logic [3:0] t, input int dup_at);
    xcnt = 0; ycnt = 0; ln_cyc = -1; done_cyc = -1; busy_cnt = 0; err_cnt = 0;
    @(negedge clk);
    cfg_r = r; cfg_e = e; cfg_t = t; start = 1'b1;
    for (int i = 1; i <= 400 && done_cyc < 0; i++) begin
      @(negedge clk);
      start = (i == dup_at);
      if (SET_XID) begin
        if (xcnt < N) begin
          cap_ifx[xcnt] = ifmap_XID_scan_in;  cap_flx[xcnt] = filter_XID_scan_in;
          cap_ipx[xcnt] = ipsum_XID_scan_in;  cap_opx[xcnt] = opsum_XID_scan_in;
        end
        xcnt++;
      end
      if (SET_YID) begin
        if (ycnt < ROW) begin
          cap_ify[ycnt] = ifmap_YID_scan_in;  cap_fly[ycnt] = filter_YID_scan_in;
          cap_ipy[ycnt] = ipsum_YID_scan_in;  cap_opy[ycnt] = opsum_YID_scan_in;
        end
        ycnt++;
      end
      if (SET_LN) ln_cyc = i;
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (done) done_cyc = i;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cfg_r = '0; cfg_e = '0; cfg_t = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, err, SET_XID, SET_YID, SET_LN} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {busy, done, err, SET_XID, SET_YID, SET_LN});
    end
    checks++;
    if (PE_en !== '0) begin errors++; $display("FAIL reset_pe_en got %h want 0", PE_en); end
    checks++;
    if (LN_config_in !== '0) begin errors++; $display("FAIL reset_ln got %b want 0", LN_config_in); end
    checks++;
    if ({ifmap_XID_scan_in, filter_XID_scan_in, ipsum_XID_scan_in, opsum_XID_scan_in,
         ifmap_YID_scan_in, filter_YID_scan_in, ipsum_YID_scan_in, opsum_YID_scan_in} !== '0) begin
      errors++; $display("FAIL reset_scan_data got nonzero want 0");
    end
  endtask

  task automatic test_full_layer();
    run_scan(4'd3, 4'd14, 4'd4, 0);
    checks++; if (done_cyc !== 182) begin errors++; $display("FAIL full_done_cycle got %0d want 182", done_cyc); end
    checks++; if (ln_cyc !== 181) begin errors++; $display("FAIL full_ln_cycle got %0d want 181", ln_cyc); end
    checks++; if (xcnt !== 168) begin errors++; $display("FAIL full_xid_shifts got %0d want 168", xcnt); end
    checks++; if (ycnt !== 12) begin errors++; $display("FAIL full_yid_shifts got %0d want 12", ycnt); end
    checks++; if (busy_cnt !== 182) begin errors++; $display("FAIL full_busy_cycles got %0d want 182", busy_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL full_err got %0d want 0", err_cnt); end
    checks++; if (LN_config_in !== 11'b11011011011) begin errors++; $display("FAIL full_ln got %b want 11011011011", LN_config_in); end
    checks++; if (PE_en !== {N{1'b1}}) begin errors++; $display("FAIL full_pe_en got %h want all ones", PE_en); end
    checks++; if (cap_ifx[61] !== 5'd6) begin errors++; $display("FAIL full_ifmap_x_4_5 got %0d want 6", cap_ifx[61]); end
    checks++; if (cap_flx[61] !== 5'd0) begin errors++; $display("FAIL full_filter_x_4_5 got %0d want 0", cap_flx[61]); end
    checks++; if (cap_opx[61] !== 5'd5) begin errors++; $display("FAIL full_opsum_x_4_5 got %0d want 5", cap_opx[61]); end
    checks++; if (cap_ifx[167] !== 5'd15) begin errors++; $display("FAIL full_ifmap_x_11_13 got %0d want 15", cap_ifx[167]); end
    checks++; if (cap_fly[4] !== 4'd1) begin errors++; $display("FAIL full_filter_y_row4 got %0d want 1", cap_fly[4]); end
    checks++; if (cap_ipy[4] !== 4'd1) begin errors++; $display("FAIL full_ipsum_y_row4 got %0d want 1", cap_ipy[4]); end
    checks++; if (cap_ify[11] !== 4'd3) begin errors++; $display("FAIL full_ifmap_y_row11 got %0d want 3", cap_ify[11]); end
  endtask

  task automatic test_partial_layer();
    run_scan(4'd3, 4'd10, 4'd2, 0);
    for (int yy = 0; yy < ROW; yy++)
      for (int xx = 0; xx < COL; xx++)
        exp_en[yy*COL + xx] = !MASKED || ((yy < 6) && (xx < 10));
    checks++; if (done_cyc !== 182) begin errors++; $display("FAIL part_done_cycle got %0d want 182", done_cyc); end
    checks++; if (LN_config_in !== 11'b00000011011) begin errors++; $display("FAIL part_ln got %b want 00000011011", LN_config_in); end
    checks++; if (PE_en !== exp_en) begin errors++; $display("FAIL part_pe_en got %h want %h", PE_en, exp_en); end
    checks++; if (cap_ifx[79] !== 5'd11) begin errors++; $display("FAIL part_ifmap_x_5_9 got %0d want 11", cap_ifx[79]); end
    checks++; if (cap_ifx[40] !== (MASKED ? 5'd31 : 5'd14)) begin errors++; $display("FAIL part_ifmap_x_2_12 got %0d want %0d", cap_ifx[40], MASKED ? 31 : 14); end
    checks++; if (cap_ipx[40] !== (MASKED ? 5'd31 : 5'd12)) begin errors++; $display("FAIL part_ipsum_x_2_12 got %0d want %0d", cap_ipx[40], MASKED ? 31 : 12); end
    checks++; if (cap_ifx[101] !== (MASKED ? 5'd31 : 5'd4)) begin errors++; $display("FAIL part_ifmap_x_7_3 got %0d want %0d", cap_ifx[101], MASKED ? 31 : 4); end
    checks++; if (cap_ify[7] !== (MASKED ? 4'd15 : 4'd2)) begin errors++; $display("FAIL part_ifmap_y_row7 got %0d want %0d", cap_ify[7], MASKED ? 15 : 2); end
    checks++; if (cap_fly[11] !== (MASKED ? 4'd15 : 4'd2)) begin errors++; $display("FAIL part_filter_y_row11 got %0d want %0d", cap_fly[11], MASKED ? 15 : 2); end
    checks++; if (cap_opy[5] !== 4'd1) begin errors++; $display("FAIL part_opsum_y_row5 got %0d want 1", cap_opy[5]); end
    @(negedge clk);
    checks++; if (PE_en !== exp_en) begin errors++; $display("FAIL part_pe_en_hold got %h want %h", PE_en, exp_en); end
  endtask

  task automatic test_invalid_start();
    logic [3:0] bad_r[3], bad_e[3], bad_t[3];
    int e_cnt, b_cnt, s_cnt;
    bad_r[0] = 4'd5; bad_e[0] = 4'd14; bad_t[0] = 4'd3;
    bad_r[1] = 4'd3; bad_e[1] = 4'd0;  bad_t[1] = 4'd4;
    bad_r[2] = 4'd1; bad_e[2] = 4'd15; bad_t[2] = 4'd1;
    for (int v = 0; v < 3; v++) begin
      e_cnt = 0; b_cnt = 0; s_cnt = 0;
      @(negedge clk);
      cfg_r = bad_r[v]; cfg_e = bad_e[v]; cfg_t = bad_t[v]; start = 1'b1;
      for (int i = 1; i <= 6; i++) begin
        @(negedge clk);
        start = 1'b0;
        if (i == 1 && !err) e_cnt = -100;
        if (err) e_cnt++;
        if (busy) b_cnt++;
        if (SET_XID || SET_YID || SET_LN || done) s_cnt++;
      end
      checks++; if (e_cnt !== 1) begin errors++; $display("FAIL invalid%0d_err_pulse got %0d want 1", v, e_cnt); end
      checks++; if (b_cnt !== 0) begin errors++; $display("FAIL invalid%0d_busy got %0d want 0", v, b_cnt); end
      checks++; if (s_cnt !== 0) begin errors++; $display("FAIL invalid%0d_strobes got %0d want 0", v, s_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    run_scan(4'd3, 4'd14, 4'd4, 50);
    checks++; if (xcnt !== 168) begin errors++; $display("FAIL dup_xid_shifts got %0d want 168", xcnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL dup_err got %0d want 0", err_cnt); end
    checks++; if (done_cyc !== 182) begin errors++; $display("FAIL dup_done_cycle got %0d want 182", done_cyc); end
    run_scan(4'd2, 4'd14, 4'd6, 0);
    checks++; if (done_cyc !== 182) begin errors++; $display("FAIL b2b_done_cycle got %0d want 182", done_cyc); end
    checks++; if (LN_config_in !== 11'b10101010101) begin errors++; $display("FAIL b2b_ln got %b want 10101010101", LN_config_in); end
    checks++; if (cap_fly[5] !== 4'd1) begin errors++; $display("FAIL b2b_filter_y_row5 got %0d want 1", cap_fly[5]); end
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    cfg_r = 4'd3; cfg_e = 4'd14; cfg_t = 4'd4; start = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++; if (SET_XID !== 1'b1) begin errors++; $display("FAIL rstmid_scanning got %b want 1", SET_XID); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, err, SET_XID, SET_YID, SET_LN} !== 6'b0) begin
      errors++; $display("FAIL rstmid_ctrl got %b want 000000", {busy, done, err, SET_XID, SET_YID, SET_LN});
    end
    checks++; if (PE_en !== '0) begin errors++; $display("FAIL rstmid_pe_en got %h want 0", PE_en); end
    checks++; if (ifmap_XID_scan_in !== '0) begin errors++; $display("FAIL rstmid_xid_data got %0d want 0", ifmap_XID_scan_in); end
    rst = 1'b0;
    run_scan(4'd3, 4'd14, 4'd4, 0);
    checks++; if (done_cyc !== 182) begin errors++; $display("FAIL rstmid_restart_done got %0d want 182", done_cyc); end
    checks++; if (xcnt !== 168) begin errors++; $display("FAIL rstmid_restart_shifts got %0d want 168", xcnt); end
  endtask

  task automatic test_tiny_layer();
    run_scan(4'd1, 4'd1, 4'd1, 0);
    exp_en = MASKED ? {{(N-1){1'b0}}, 1'b1} : {N{1'b1}};
    checks++; if (done_cyc !== 182) begin errors++; $display("FAIL tiny_done_cycle got %0d want 182", done_cyc); end
    checks++; if (LN_config_in !== '0) begin errors++; $display("FAIL tiny_ln got %b want 0", LN_config_in); end
    checks++; if (PE_en !== exp_en) begin errors++; $display("FAIL tiny_pe_en got %h want %h", PE_en, exp_en); end
    checks++; if (cap_ifx[167] !== (MASKED ? 5'd31 : 5'd13)) begin errors++; $display("FAIL tiny_ifmap_x_11_13 got %0d want %0d", cap_ifx[167], MASKED ? 31 : 13); end
    checks++; if (cap_ify[11] !== (MASKED ? 4'd15 : 4'd11)) begin errors++; $display("FAIL tiny_ifmap_y_row11 got %0d want %0d", cap_ify[11], MASKED ? 15 : 11); end
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_partial_layer();
    test_invalid_start();
    test_back_to_back();
    test_reset_mid_scan();
    test_tiny_layer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
